// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - shared types and helpers for the parametrised tape machine
package tm_pkg;

  // head movement encoded in a rule entry; both stay codes leave the head alone
  typedef enum logic [1:0] {
    MV_STAY  = 2'b00,
    MV_RIGHT = 2'b01,
    MV_LEFT  = 2'b10,
    MV_HOLD  = 2'b11
  } move_t;

  // reason the last run stopped
  typedef enum logic [1:0] {
    ST_NONE   = 2'b00,
    ST_HALT   = 2'b01,
    ST_BOUNDS = 2'b10,
    ST_LIMIT  = 2'b11
  } status_t;

  // controller states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } fsm_t;

  // a run is in progress in these states; config writes and start are locked out
  function automatic logic fsm_busy(input fsm_t s);
    return (s == S_FETCH) || (s == S_EXEC) || (s == S_PAUSE);
  endfunction

endpackage

// File: rtl/tm_regfile.sv
// rtl/tm_regfile.sv - reset-cleared storage array, one write port, two read ports
module tm_regfile #(
  parameter int W  = 2,
  parameter int D  = 32,
  parameter int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem [D];

  // whole array clears on reset; writes past the last entry are dropped
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < D)) begin
      mem[waddr] <= wdata;
    end
  end

  // combinational reads; addresses past the end read as blank
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (32'(raddr_a) < D) rdata_a = mem[raddr_a];
    if (32'(raddr_b) < D) rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/tm_engine_param.sv
// rtl/tm_engine_param.sv - parametrised multi-symbol tape machine with step control
module tm_engine_param
  import tm_pkg::*;
#(
  parameter int  SW        = 2,
  parameter int  NS        = 8,
  parameter int  TD        = 32,
  parameter int  MAX_STEPS = 1023,
  localparam int STW       = (NS > 1) ? $clog2(NS) : 1,
  localparam int HW        = (TD > 1) ? $clog2(TD) : 1,
  localparam int RA        = STW + SW,
  localparam int AW        = (HW > RA) ? HW : RA,
  localparam int DW        = 3 + STW + SW,
  localparam int CW        = $clog2(MAX_STEPS + 1)
) (
  input  logic           clock,
  input  logic           Reset,
  input  logic           cfg_we,
  input  logic           cfg_sel,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [DW-1:0]  cfg_data,
  input  logic           start,
  input  logic [HW-1:0]  start_head,
  input  logic           step_mode,
  input  logic           Next,
  input  logic           abort,
  input  logic [HW-1:0]  rd_addr,
  output logic [SW-1:0]  rd_data,
  output logic           busy,
  output logic           done,
  output logic [1:0]     status,
  output logic [HW-1:0]  head,
  output logic [STW-1:0] state,
  output logic [CW-1:0]  step_count
);

  // rule layout depends on the alphabet and state-count parameters
  typedef struct packed {
    logic           halt;
    move_t          move;
    logic [STW-1:0] next_state;
    logic [SW-1:0]  write_sym;
  } rule_t;

  localparam int RD = NS * (1 << SW);

  fsm_t           fsm_q, fsm_d;
  logic [HW-1:0]  head_q;
  logic [STW-1:0] mstate_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_inc;
  status_t        status_q;
  logic [SW-1:0]  sym_q;
  logic           mode_q;
  logic           next_q;
  logic           next_rise;

  logic           run_go;
  logic           commit;
  logic           head_step;
  logic           term;
  status_t        term_status;
  logic           at_edge;

  logic           cfg_ok;
  logic           tape_cfg_we;
  logic           rule_cfg_we;
  logic           tape_we;
  logic [HW-1:0]  tape_waddr;
  logic [SW-1:0]  tape_wdata;
  logic [SW-1:0]  tape_head_sym;
  logic [DW-1:0]  rule_rd;
  logic [DW-1:0]  rule_unused_b;
  rule_t          rule;

  assign busy       = fsm_busy(fsm_q);
  assign done       = (fsm_q == S_DONE);
  assign status     = status_q;
  assign head       = head_q;
  assign state      = mstate_q;
  assign step_count = cnt_q;

  assign next_rise  = Next & ~next_q;
  assign cnt_inc    = cnt_q + 1'b1;
  assign rule       = rule_t'(rule_rd);
  assign at_edge    = ((rule.move == MV_RIGHT) && (head_q == HW'(TD - 1))) ||
                      ((rule.move == MV_LEFT)  && (head_q == '0));

  // config writes only land while no run is active and the address is in range
  assign cfg_ok      = cfg_we && !busy;
  assign tape_cfg_we = cfg_ok && !cfg_sel && (32'(cfg_addr) < TD);
  assign rule_cfg_we = cfg_ok &&  cfg_sel && (32'(cfg_addr >> SW) < NS);

  // the engine's own write owns the tape during EXEC; config owns it otherwise
  assign tape_we    = commit | tape_cfg_we;
  assign tape_waddr = commit ? head_q : cfg_addr[HW-1:0];
  assign tape_wdata = commit ? rule.write_sym : cfg_data[SW-1:0];

  tm_regfile #(.W(SW), .D(TD), .AW(HW)) u_tape (
    .clock   (clock),
    .Reset   (Reset),
    .we      (tape_we),
    .waddr   (tape_waddr),
    .wdata   (tape_wdata),
    .raddr_a (head_q),
    .rdata_a (tape_head_sym),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

  tm_regfile #(.W(DW), .D(RD), .AW(RA)) u_rules (
    .clock   (clock),
    .Reset   (Reset),
    .we      (rule_cfg_we),
    .waddr   (cfg_addr[RA-1:0]),
    .wdata   (cfg_data),
    .raddr_a ({mstate_q, sym_q}),
    .rdata_a (rule_rd),
    .raddr_b ('0),
    .rdata_b (rule_unused_b)
  );

  // controller state register
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  // next state plus the per-cycle run/commit/terminate decisions
  always_comb begin
    fsm_d       = fsm_q;
    run_go      = 1'b0;
    commit      = 1'b0;
    head_step   = 1'b0;
    term        = 1'b0;
    term_status = ST_NONE;
    unique case (fsm_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          fsm_d  = S_FETCH;
          run_go = 1'b1;
        end
      end
      S_FETCH: fsm_d = abort ? S_IDLE : S_EXEC;
      S_EXEC: begin
        if (abort) begin
          fsm_d = S_IDLE;
        end else begin
          commit = 1'b1;
          if (rule.halt) begin
            term        = 1'b1;
            term_status = ST_HALT;
          end else if (at_edge) begin
            term        = 1'b1;
            term_status = ST_BOUNDS;
          end else begin
            head_step = (rule.move == MV_RIGHT) || (rule.move == MV_LEFT);
            if (cnt_inc == CW'(MAX_STEPS)) begin
              term        = 1'b1;
              term_status = ST_LIMIT;
            end
          end
          if (term)        fsm_d = S_DONE;
          else if (mode_q) fsm_d = S_PAUSE;
          else             fsm_d = S_FETCH;
        end
      end
      S_PAUSE: begin
        if (abort)          fsm_d = S_IDLE;
        else if (next_rise) fsm_d = S_FETCH;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // machine registers: loaded at start, symbol latched in FETCH, updated on commit
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      head_q   <= '0;
      mstate_q <= '0;
      cnt_q    <= '0;
      status_q <= ST_NONE;
      sym_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      if (run_go) begin
        head_q   <= start_head;
        mstate_q <= '0;
        cnt_q    <= '0;
        status_q <= ST_NONE;
        mode_q   <= step_mode;
      end
      if (fsm_q == S_FETCH) sym_q <= tape_head_sym;
      if (commit) begin
        mstate_q <= rule.next_state;
        cnt_q    <= cnt_inc;
        if (head_step) head_q <= (rule.move == MV_RIGHT) ? head_q + 1'b1 : head_q - 1'b1;
        if (term)      status_q <= term_status;
      end
    end
  end

  // Next edge detector; starts low so a level held before reset release is not lost
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) next_q <= 1'b0;
    else       next_q <= Next;
  end

endmodule

// File: tb/tb_tm_engine_param.sv
// tb/tb_tm_engine_param.sv - self-checking bench for tm_engine_param
module tb_tm_engine_param;

  localparam int TD   = 32;
  localparam int NS   = 8;
  localparam int MAXS = 1023;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic [4:0] start_head = '0;
  logic       step_mode = 1'b0;
  logic       Next = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] rd_addr = '0;

  logic [1:0] rd_data, status;
  logic       busy, done;
  logic [4:0] head;
  logic [2:0] state;
  logic [9:0] step_count;

  logic [1:0] rd_data_l, status_l;
  logic       busy_l, done_l;
  logic [4:0] head_l;
  logic [2:0] state_l;
  logic [3:0] count_l;

  int checks = 0;
  int errors = 0;

  int m_tape [TD];
  int m_halt [NS*4];
  int m_mv   [NS*4];
  int m_ns   [NS*4];
  int m_ws   [NS*4];

  always #5 clock = ~clock;

  tm_engine_param #(.SW(2), .NS(8), .TD(32), .MAX_STEPS(1023)) dut (
    .clock(clock), .Reset(Reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .start_head(start_head), .step_mode(step_mode),
    .Next(Next), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .status(status), .head(head), .state(state), .step_count(step_count)
  );

  tm_engine_param #(.SW(2), .NS(8), .TD(24), .MAX_STEPS(8)) dut_lim (
    .clock(clock), .Reset(Reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .start_head(start_head), .step_mode(step_mode),
    .Next(Next), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data_l), .busy(busy_l),
    .done(done_l), .status(status_l), .head(head_l), .state(state_l), .step_count(count_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TD; i++) m_tape[i] = 0;
    for (int i = 0; i < NS*4; i++) begin
      m_halt[i] = 0; m_mv[i] = 0; m_ns[i] = 0; m_ws[i] = 0;
    end
  endtask

  task automatic cfg_tape(input int a, input int v, input bit take);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'(a); cfg_data = 8'(v);
    @(negedge clock);
    cfg_we = 1'b0;
    if (take && a < TD) m_tape[a] = v;
  endtask

  task automatic cfg_rule(input int st, input int sym, input int h, input int mv,
                          input int ns, input int ws, input bit take);
    int idx;
    idx = st * 4 + sym;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'(idx);
    cfg_data = 8'((h << 7) | (mv << 5) | (ns << 2) | ws);
    @(negedge clock);
    cfg_we = 1'b0;
    if (take) begin
      m_halt[idx] = h; m_mv[idx] = mv; m_ns[idx] = ns; m_ws[idx] = ws;
    end
  endtask

  task automatic clear_tape();
    for (int a = 0; a < TD; a++) cfg_tape(a, 0, 1'b1);
  endtask

  task automatic launch(input int h, input bit mode);
    start_head = 5'(h); step_mode = mode; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_next();
    Next = 1'b0;
    @(negedge clock);
    Next = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("done_within_budget", done, 1);
  endtask

  task automatic check_tape(input string tag);
    for (int i = 0; i < TD; i++) begin
      rd_addr = 5'(i);
      #1;
      chk($sformatf("%s_tape%0d", tag, i), rd_data, m_tape[i]);
    end
    @(negedge clock);
  endtask

  // sequential interpreter of the machine rules; updates the model tape in place
  task automatic model_run(input int h0, output int steps, output int fh,
                           output int fs, output int fst);
    int h, s, n, idx;
    h = h0; s = 0; n = 0; fst = 0;
    while (fst == 0) begin
      idx = s * 4 + m_tape[h];
      m_tape[h] = m_ws[idx];
      s = m_ns[idx];
      n++;
      if (m_halt[idx] != 0) fst = 1;
      else if ((m_mv[idx] == 1 && h == TD-1) || (m_mv[idx] == 2 && h == 0)) fst = 2;
      else begin
        if (m_mv[idx] == 1) h++;
        else if (m_mv[idx] == 2) h--;
        if (n == MAXS) fst = 3;
      end
    end
    steps = n; fh = h; fs = s;
  endtask

  initial begin
    int cyc, e_steps, e_head, e_state, e_status, h;
    model_clear();

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_head", head, 0);
    chk("rst_state", state, 0);
    chk("rst_count", step_count, 0);
    chk("rst_tape0", rd_data, 0);
    Reset = 1'b0;
    @(negedge clock);

    // unary filler; tape[4] written in the same cycle as start
    cfg_rule(0, 0, 0, 1, 0, 1, 1'b1);
    cfg_rule(0, 1, 1, 0, 0, 1, 1'b1);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd4; cfg_data = 8'd1;
    start = 1'b1; start_head = 5'd0; step_mode = 1'b0;
    m_tape[4] = 1;
    @(negedge clock);
    cfg_we = 1'b0; start = 1'b0;
    model_run(0, e_steps, e_head, e_state, e_status);
    wait_done(100, cyc);
    chk("t1_cycles", cyc, 10);
    chk("t1_status", status, 1);
    chk("t1_head", head, 4);
    chk("t1_count", step_count, 5);
    chk("t1_busy", busy, 0);
    check_tape("t1");

    // bounds at the left end
    clear_tape();
    cfg_rule(0, 0, 0, 2, 0, 2, 1'b1);
    launch(2, 1'b0);
    model_run(2, e_steps, e_head, e_state, e_status);
    wait_done(100, cyc);
    chk("t2_status", status, 2);
    chk("t2_head", head, 0);
    chk("t2_count", step_count, 3);
    chk("t2_cycles", cyc, 6);
    check_tape("t2");

    // step limit on the MAX_STEPS=8 instance
    cfg_rule(0, 0, 0, 0, 0, 0, 1'b1);
    launch(5, 1'b0);
    repeat (15) @(negedge clock);
    chk("t3_done_early", done_l, 0);
    @(negedge clock);
    chk("t3_done_at16", done_l, 1);
    chk("t3_status", status_l, 3);
    chk("t3_count", count_l, 8);
    chk("t3_head", head_l, 5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_status", status, 0);

    // single-step with Next held high through start
    clear_tape();
    cfg_tape(4, 1, 1'b1);
    cfg_rule(0, 0, 0, 1, 0, 1, 1'b1);
    Next = 1'b1;
    launch(0, 1'b1);
    repeat (6) @(negedge clock);
    chk("t4_first_step", step_count, 1);
    chk("t4_pause_busy", busy, 1);
    chk("t4_pause_done", done, 0);
    pulse_next();
    chk("t4_one_rise", step_count, 2);
    repeat (4) @(negedge clock);
    chk("t4_held_high", step_count, 2);
    for (int k = 0; k < 3; k++) pulse_next();
    model_run(0, e_steps, e_head, e_state, e_status);
    chk("t4_done", done, 1);
    chk("t4_status", status, e_status);
    chk("t4_count", step_count, e_steps);
    chk("t4_head", head, e_head);
    check_tape("t4");

    // abort after three steps keeps the committed writes
    clear_tape();
    cfg_tape(4, 1, 1'b1);
    Next = 1'b0;
    launch(0, 1'b1);
    repeat (4) @(negedge clock);
    pulse_next();
    pulse_next();
    chk("t5_count3", step_count, 3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    for (int i = 0; i < 3; i++) m_tape[i] = 1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_status", status, 0);
    check_tape("t5");

    // Reset asserted while in EXEC
    launch(0, 1'b0);
    @(negedge clock);
    #2 Reset = 1'b1;
    rd_addr = 5'd0;
    #1;
    chk("t5r_busy", busy, 0);
    chk("t5r_done", done, 0);
    chk("t5r_status", status, 0);
    chk("t5r_head", head, 0);
    chk("t5r_state", state, 0);
    chk("t5r_count", step_count, 0);
    chk("t5r_tape0", rd_data, 0);
    rd_addr = 5'd4;
    #1;
    chk("t5r_tape4", rd_data, 0);
    @(negedge clock);
    Reset = 1'b0;
    model_clear();
    @(negedge clock);

    // config writes while busy are ignored
    cfg_rule(0, 0, 0, 1, 0, 1, 1'b1);
    cfg_rule(0, 1, 1, 0, 0, 1, 1'b1);
    cfg_tape(4, 1, 1'b1);
    launch(0, 1'b0);
    cfg_tape(0, 3, 1'b0);
    cfg_rule(0, 1, 0, 1, 0, 2, 1'b0);
    model_run(0, e_steps, e_head, e_state, e_status);
    wait_done(100, cyc);
    chk("t6_cycles", cyc + 2, 2 * e_steps);
    chk("t6_status", status, e_status);
    chk("t6_count", step_count, e_steps);
    check_tape("t6");
    cfg_tape(24, 3, 1'b1);
    rd_addr = 5'd24;
    #1;
    chk("t6_drop_lim", rd_data_l, 0);
    chk("t6_keep_main", rd_data, 3);
    @(negedge clock);

    // randomized programs against the interpreter
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < TD; a++) cfg_tape(a, int'($urandom_range(0, 3)), 1'b1);
      for (int a = 0; a < NS*4; a++)
        cfg_rule(a / 4, a % 4, ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, NS-1)), int'($urandom_range(0, 3)), 1'b1);
      h = int'($urandom_range(0, TD-1));
      launch(h, 1'b0);
      model_run(h, e_steps, e_head, e_state, e_status);
      wait_done(2 * MAXS + 20, cyc);
      chk($sformatf("rnd%0d_cycles", r), cyc, 2 * e_steps);
      chk($sformatf("rnd%0d_status", r), status, e_status);
      chk($sformatf("rnd%0d_head", r), head, e_head);
      chk($sformatf("rnd%0d_state", r), state, e_state);
      chk($sformatf("rnd%0d_count", r), step_count, e_steps);
      check_tape($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
